// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl -- set-mode controller for a HH:MM:ss.mm time counter.
// Generates the 1/100 s count enable, synchronizes the three buttons,
// and sequences RUN -> SET_HOUR -> SET_MIN -> RUN.
// Optional alarm: define CLOCK_SET_CTRL_ALARM_EN to add the ALARM port,
// the alarm register and the armed flag.
module clock_set_ctrl #(
  parameter int unsigned DIV = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BTN_MODE,
  input  logic        BTN_SET,
  input  logic        BTN_CLR,
  input  logic [31:0] TIME,
  output logic        CE10,
  output logic        SETH,
  output logic        SETM,
  output logic        SCLR,
  output logic [1:0]  MODE
`ifdef CLOCK_SET_CTRL_ALARM_EN
  ,
  output logic        ALARM
`endif
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HOUR = 2'b01,
    ST_MIN  = 2'b10
  } state_t;

  // Button vector order: [0] MODE, [1] SET, [2] CLR
  logic [2:0]    btn_s;
  logic [2:0]    sync1_r;
  logic [2:0]    sync2_r;
  logic [2:0]    prev_r;
  logic          mode_edge_s;
  logic          clr_edge_s;
  logic          consume_s;

  logic [CW-1:0] cnt_r;
  logic          ce_r;

  state_t        state_r;
  state_t        state_next_s;
  logic          sclr_next_s;
  logic          sclr_r;
  logic          seth_r;
  logic          setm_r;

  assign btn_s       = {BTN_CLR, BTN_SET, BTN_MODE};
  assign mode_edge_s = sync2_r[0] & ~prev_r[0];
  assign clr_edge_s  = sync2_r[2] & ~prev_r[2];

`ifdef CLOCK_SET_CTRL_ALARM_EN
  logic          set_edge_s;
  logic          armed_r;
  logic          alarm_r;
  logic [15:0]   alarm_reg_r;

  assign set_edge_s = sync2_r[1] & ~prev_r[1];
  // While the alarm is showing, any button edge only acknowledges it
  assign consume_s  = alarm_r & (mode_edge_s | clr_edge_s | set_edge_s);
  assign ALARM      = alarm_r;
`else
  logic          unused_s;

  assign consume_s = 1'b0;
  assign unused_s  = ^{TIME, prev_r[1]};
`endif

  // Two-flop synchronizers plus one delay stage for rising-edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      prev_r  <= 3'b000;
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Free-running 1/100 s prescaler; never stalled by the FSM
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= '0;
      ce_r  <= 1'b0;
    end else begin
      ce_r <= (cnt_r == CW'(DIV - 1));
      if (cnt_r == CW'(DIV - 1)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Next state and seconds-clear request; MODE edge wins over CLR edge
  always_comb begin
    state_next_s = state_r;
    sclr_next_s  = 1'b0;
    if (consume_s) begin
      state_next_s = state_r;
      sclr_next_s  = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mode_edge_s) begin
            state_next_s = ST_HOUR;
          end else if (clr_edge_s) begin
            sclr_next_s = 1'b1;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_HOUR: begin
          if (mode_edge_s) begin
            state_next_s = ST_MIN;
          end else begin
            state_next_s = ST_HOUR;
          end
        end
        ST_MIN: begin
          if (mode_edge_s) begin
            state_next_s = ST_RUN;
            sclr_next_s  = 1'b1;
          end else begin
            state_next_s = ST_MIN;
          end
        end
        default: begin
          state_next_s = ST_RUN;
          sclr_next_s  = 1'b0;
        end
      endcase
    end
  end

  // State and registered set/clear outputs; SETH/SETM follow the next state so
  // they drop in the same cycle the set state is left
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_RUN;
      sclr_r  <= 1'b0;
      seth_r  <= 1'b0;
      setm_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      sclr_r  <= sclr_next_s;
      seth_r  <= (state_next_s == ST_HOUR) & sync1_r[1];
      setm_r  <= (state_next_s == ST_MIN) & sync1_r[1];
    end
  end

`ifdef CLOCK_SET_CTRL_ALARM_EN
  // Alarm capture in RUN, match on HH:MM at ss.mm == 00.00, clear on any edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      armed_r     <= 1'b0;
      alarm_r     <= 1'b0;
      alarm_reg_r <= 16'h0000;
    end else if (consume_s) begin
      armed_r     <= 1'b0;
      alarm_r     <= 1'b0;
      alarm_reg_r <= alarm_reg_r;
    end else begin
      if (armed_r && (TIME[31:16] == alarm_reg_r) && (TIME[15:0] == 16'h0000)) begin
        alarm_r <= 1'b1;
      end else begin
        alarm_r <= alarm_r;
      end
      if ((state_r == ST_RUN) && set_edge_s) begin
        alarm_reg_r <= TIME[31:16];
        armed_r     <= 1'b1;
      end else begin
        alarm_reg_r <= alarm_reg_r;
        armed_r     <= armed_r;
      end
    end
  end
`endif

  assign CE10 = ce_r;
  assign SETH = seth_r;
  assign SETM = setm_r;
  assign SCLR = sclr_r;
  assign MODE = state_r;

endmodule
